// File: rtl/qa_input_debounce.sv
// Board input front end: 2-FF synchronisers plus tick-sampled debouncing for 4 buttons and 8 switches.
// Emits clean levels and one-cycle press/release/change pulses aligned with each level flip.
module qa_input_debounce #(
   parameter int TICK_DIV       = 240_000,
   parameter int STABLE_CNT     = 3,
   parameter bit BTN_ACTIVE_LOW = 1'b1
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic [3:0] push_button,
   input  logic [7:0] toggle_switch,
   output logic [3:0] btn_level,
   output logic [3:0] btn_press,
   output logic [3:0] btn_release,
   output logic [7:0] sw_level,
   output logic       sw_change,
   output logic       tick
);

   localparam int             CW        = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0]  TICK_LAST = CW'(TICK_DIV - 1);
   localparam logic [3:0]     CNT_LAST  = 4'(STABLE_CNT - 1);
   localparam logic [3:0]     BTN_IDLE  = BTN_ACTIVE_LOW ? 4'hF : 4'h0;

   logic [3:0]        btn_s1, btn_s2;
   logic [7:0]        sw_s1, sw_s2;
   logic [CW-1:0]     tick_cnt;
   logic [11:0]       sample;
   logic [11:0]       level_q;
   logic [11:0]       flip;
   logic [11:0][3:0]  stable_q, stable_d;

   // Sync flops reset to the released/off raw value so reset itself never looks like an edge.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         btn_s1 <= BTN_IDLE;
         btn_s2 <= BTN_IDLE;
         sw_s1  <= '0;
         sw_s2  <= '0;
      end else begin
         btn_s1 <= push_button;
         btn_s2 <= btn_s1;
         sw_s1  <= toggle_switch;
         sw_s2  <= sw_s1;
      end
   end

   assign sample = {sw_s2, (BTN_ACTIVE_LOW ? ~btn_s2 : btn_s2)};

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         tick_cnt <= '0;
      end else if (tick_cnt == TICK_LAST) begin
         tick_cnt <= '0;
      end else begin
         tick_cnt <= tick_cnt + CW'(1);
      end
   end

   assign tick = (tick_cnt == TICK_LAST);

   // A sample equal to the level on any tick restarts that bit's run.
   always_comb begin
      flip     = '0;
      stable_d = stable_q;
      if (tick) begin
         for (int i = 0; i < 12; i++) begin
            if (sample[i] == level_q[i]) begin
               stable_d[i] = '0;
            end else if (stable_q[i] == CNT_LAST) begin
               flip[i]     = 1'b1;
               stable_d[i] = '0;
            end else begin
               stable_d[i] = stable_q[i] + 4'd1;
            end
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         level_q     <= '0;
         stable_q    <= '0;
         btn_press   <= '0;
         btn_release <= '0;
         sw_change   <= 1'b0;
      end else begin
         level_q     <= level_q ^ flip;
         stable_q    <= stable_d;
         btn_press   <= flip[3:0] & sample[3:0];
         btn_release <= flip[3:0] & ~sample[3:0];
         sw_change   <= |flip[11:4];
      end
   end

   assign btn_level = level_q[3:0];
   assign sw_level  = level_q[11:4];

endmodule

// File: tb/tb_qa_input_debounce.sv
// Bench for qa_input_debounce with TICK_DIV=4, STABLE_CNT=3, active-low buttons.
// Expected pulse events are queued at stimulus time and matched by a monitor when pulses appear.
module tb_qa_input_debounce;

   logic       clock;
   logic       reset_n;
   logic [3:0] push_button;
   logic [7:0] toggle_switch;
   logic [3:0] btn_level;
   logic [3:0] btn_press;
   logic [3:0] btn_release;
   logic [7:0] sw_level;
   logic       sw_change;
   logic       tick;

   int total = 0;
   int bad   = 0;

   // event word: {btn_press, btn_release, sw_change, btn_level, sw_level}
   logic [20:0] exp_q[$];

   qa_input_debounce #(
      .TICK_DIV(4),
      .STABLE_CNT(3),
      .BTN_ACTIVE_LOW(1'b1)
   ) dut (
      .clock(clock),
      .reset_n(reset_n),
      .push_button(push_button),
      .toggle_switch(toggle_switch),
      .btn_level(btn_level),
      .btn_press(btn_press),
      .btn_release(btn_release),
      .sw_level(sw_level),
      .sw_change(sw_change),
      .tick(tick)
   );

   // clock / reset
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // monitor: every pulse cycle must match the head of the expected queue
   always @(negedge clock) begin
      logic [20:0] obs;
      logic [20:0] e;
      if (btn_press != 4'h0 || btn_release != 4'h0 || sw_change) begin
         obs = {btn_press, btn_release, sw_change, btn_level, sw_level};
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_pulse got=%h exp=none at %0t", obs, $time);
         end else begin
            e = exp_q.pop_front();
            if (obs !== e) begin
               bad++;
               $display("FAIL pulse_event got=%h exp=%h at %0t", obs, e, $time);
            end
         end
      end
   end

   // driver helpers
   task automatic wait_btn(input int b, input logic val, output int lat);
      lat = -1;
      for (int n = 1; n <= 30; n++) begin
         @(posedge clock);
         @(negedge clock);
         if (btn_level[b] === val) begin
            lat = n;
            break;
         end
      end
   endtask

   task automatic wait_sw(output int lat);
      lat = -1;
      for (int n = 1; n <= 30; n++) begin
         @(posedge clock);
         @(negedge clock);
         if (sw_change === 1'b1) begin
            lat = n;
            break;
         end
      end
   endtask

   task automatic test_reset();
      int ticks = 0;
      int last = -1;
      int gap_bad = 0;
      int lvl_bad = 0;
      reset_n       = 1'b0;
      push_button   = 4'hF;
      toggle_switch = 8'h00;
      repeat (3) @(posedge clock);
      @(negedge clock);
      total++;
      if ({btn_level, btn_press, btn_release, sw_level, sw_change, tick} !== 26'h0) begin
         bad++;
         $display("FAIL reset_outputs got=%h exp=0",
                  {btn_level, btn_press, btn_release, sw_level, sw_change, tick});
      end
      reset_n = 1'b1;
      for (int i = 1; i <= 100; i++) begin
         @(negedge clock);
         if (tick === 1'b1) begin
            ticks++;
            if (last >= 0 && (i - last) != 4) gap_bad++;
            last = i;
         end
         if (btn_level !== 4'h0 || sw_level !== 8'h00) lvl_bad++;
      end
      total++;
      if (ticks != 25) begin
         bad++;
         $display("FAIL tick_count got=%0d exp=25", ticks);
      end
      total++;
      if (gap_bad != 0) begin
         bad++;
         $display("FAIL tick_spacing got=%0d bad gaps exp=0", gap_bad);
      end
      total++;
      if (lvl_bad != 0) begin
         bad++;
         $display("FAIL idle_levels got=%0d nonzero cycles exp=0", lvl_bad);
      end
   endtask

   task automatic test_press_release();
      int lat;
      @(posedge clock); #1;
      push_button[0] = 1'b0;
      exp_q.push_back({4'b0001, 4'b0000, 1'b0, 4'b0001, 8'h00});
      wait_btn(0, 1'b1, lat);
      total++;
      if (lat < 11 || lat > 14) begin
         bad++;
         $display("FAIL press_latency got=%0d exp=11..14", lat);
      end
      @(posedge clock);
      @(negedge clock);
      total++;
      if (btn_press !== 4'b0000) begin
         bad++;
         $display("FAIL press_width got=%b exp=0000", btn_press);
      end
      repeat (10) @(posedge clock);
      #1;
      push_button[0] = 1'b1;
      exp_q.push_back({4'b0000, 4'b0001, 1'b0, 4'b0000, 8'h00});
      wait_btn(0, 1'b0, lat);
      total++;
      if (lat < 11 || lat > 14) begin
         bad++;
         $display("FAIL release_latency got=%0d exp=11..14", lat);
      end
      repeat (10) @(posedge clock);
   endtask

   task automatic test_bounce();
      for (int i = 0; i < 20; i++) begin
         repeat (3) @(posedge clock);
         #1;
         push_button[2] = ~push_button[2];
      end
      repeat (20) @(posedge clock);
      @(negedge clock);
      total++;
      if (btn_level[2] !== 1'b0) begin
         bad++;
         $display("FAIL bounce_level got=%b exp=0", btn_level[2]);
      end
   endtask

   task automatic test_switch();
      int lat;
      @(posedge clock); #1;
      toggle_switch = 8'hA5;
      exp_q.push_back({4'b0000, 4'b0000, 1'b1, 4'b0000, 8'hA5});
      wait_sw(lat);
      total++;
      if (lat < 11 || lat > 14 || sw_level !== 8'hA5) begin
         bad++;
         $display("FAIL switch_on got lat=%0d level=%h exp lat=11..14 level=a5", lat, sw_level);
      end
      @(posedge clock);
      @(negedge clock);
      total++;
      if (sw_change !== 1'b0) begin
         bad++;
         $display("FAIL switch_width got=%b exp=0", sw_change);
      end
      repeat (10) @(posedge clock);
      #1;
      toggle_switch = 8'h00;
      exp_q.push_back({4'b0000, 4'b0000, 1'b1, 4'b0000, 8'h00});
      wait_sw(lat);
      total++;
      if (lat < 11 || lat > 14 || sw_level !== 8'h00) begin
         bad++;
         $display("FAIL switch_off got lat=%0d level=%h exp lat=11..14 level=00", lat, sw_level);
      end
      repeat (10) @(posedge clock);
   endtask

   task automatic test_reset_mid();
      int lat;
      @(posedge clock); #1;
      push_button[1] = 1'b0;
      repeat (8) @(posedge clock);
      #1;
      reset_n = 1'b0;
      @(negedge clock);
      total++;
      if ({btn_level, btn_press, btn_release, sw_level, sw_change, tick} !== 26'h0) begin
         bad++;
         $display("FAIL midreset_outputs got=%h exp=0",
                  {btn_level, btn_press, btn_release, sw_level, sw_change, tick});
      end
      repeat (3) @(posedge clock);
      #1;
      reset_n = 1'b1;
      exp_q.push_back({4'b0010, 4'b0000, 1'b0, 4'b0010, 8'h00});
      wait_btn(1, 1'b1, lat);
      total++;
      if (lat < 11 || lat > 14) begin
         bad++;
         $display("FAIL midreset_press_latency got=%0d exp=11..14", lat);
      end
      repeat (10) @(posedge clock);
      #1;
      push_button[1] = 1'b1;
      exp_q.push_back({4'b0000, 4'b0010, 1'b0, 4'b0000, 8'h00});
      wait_btn(1, 1'b0, lat);
      repeat (10) @(posedge clock);
   endtask

   task automatic test_back_to_back();
      int lat;
      @(posedge clock); #1;
      push_button = 4'b0110;
      exp_q.push_back({4'b1001, 4'b0000, 1'b0, 4'b1001, 8'h00});
      wait_btn(3, 1'b1, lat);
      total++;
      if (lat < 11 || lat > 14 || btn_press !== 4'b1001) begin
         bad++;
         $display("FAIL dual_press got lat=%0d press=%b exp lat=11..14 press=1001", lat, btn_press);
      end
      repeat (10) @(posedge clock);
      #1;
      push_button = 4'b1111;
      exp_q.push_back({4'b0000, 4'b1001, 1'b0, 4'b0000, 8'h00});
      wait_btn(0, 1'b0, lat);
      total++;
      if (lat < 11 || lat > 14 || btn_release !== 4'b1001) begin
         bad++;
         $display("FAIL dual_release got lat=%0d rel=%b exp lat=11..14 rel=1001", lat, btn_release);
      end
      repeat (10) @(posedge clock);
   endtask

   initial begin
      test_reset();
      test_press_release();
      test_bounce();
      test_switch();
      test_reset_mid();
      test_back_to_back();
      repeat (20) @(posedge clock);
      @(negedge clock);
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL pending_events got=%0d exp=0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
